// File: rtl/selector_estado.sv
// selector_estado: derives the committed pet state code from need levels and the sleep flag.
// Non-urgent changes must persist DWELL second ticks; urgent ones commit immediately.
// Also drives a one-cycle change strobe, an alert flag and a 2-bit animation frame.
module selector_estado #(
  parameter int unsigned DWELL       = 3,
  parameter int unsigned FRAME_TICKS = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       passsecond,
  input  logic [2:0] salud,
  input  logic [2:0] alimentacion,
  input  logic [2:0] energia,
  input  logic [2:0] entretenimiento,
  input  logic [2:0] higiene,
  input  logic       dormido,
  output logic [3:0] estado,
  output logic       cambio,
  output logic       alerta,
  output logic [1:0] frame
);

  localparam logic [3:0] CodeFeliz      = 4'b0000;
  localparam logic [3:0] CodeCansado    = 4'b0001;
  localparam logic [3:0] CodeDormido    = 4'b0010;
  localparam logic [3:0] CodeHambriento = 4'b0011;
  localparam logic [3:0] CodeEnfermo    = 4'b0100;
  localparam logic [3:0] CodeAburrido   = 4'b0101;
  localparam logic [3:0] CodeSucio      = 4'b0110;
  localparam logic [3:0] CodeCritico    = 4'b0111;
  localparam logic [3:0] CodeMoribundo  = 4'b1000;
  localparam logic [3:0] CodeNeutral    = 4'b1010;

  localparam logic [3:0] DwellLim = 4'(DWELL);
  localparam logic [3:0] FrameLim = 4'(FRAME_TICKS);

  typedef enum logic [0:0] {StEstable = 1'b0, StPendiente = 1'b1} state_e;

  state_e     state_q, state_d;
  logic [3:0] cand, cand_q;
  logic [3:0] estado_q, estado_d;
  logic [3:0] pend_q, pend_d;
  logic [3:0] dwell_q, dwell_d, dwell_inc;
  logic [3:0] tick_cnt_q, tick_cnt_d, tick_inc;
  logic [1:0] frame_q, frame_d;
  logic       cambio_q, cambio_d;
  logic       alerta_q, alerta_d;
  logic       passsecond_q;
  logic       tk;
  logic       commit;
  logic       cand_urgent;

  assign tk          = passsecond & ~passsecond_q;
  assign cand_urgent = (cand_q == CodeMoribundo) || (cand_q == CodeCritico) ||
                       (cand_q == CodeDormido);

  // Candidate state from the current levels, first match wins.
  always_comb begin
    cand = CodeNeutral;
    if (salud <= 3'd1) begin
      cand = CodeMoribundo;
    end else if (salud <= 3'd2 || alimentacion <= 3'd2 || energia <= 3'd2) begin
      cand = CodeCritico;
    end else if (dormido) begin
      cand = CodeDormido;
    end else if (salud <= 3'd4) begin
      cand = CodeEnfermo;
    end else if (alimentacion <= 3'd4) begin
      cand = CodeHambriento;
    end else if (energia <= 3'd4) begin
      cand = CodeCansado;
    end else if (higiene <= 3'd4) begin
      cand = CodeSucio;
    end else if (entretenimiento <= 3'd4) begin
      cand = CodeAburrido;
    end else if (salud == 3'd7 && alimentacion == 3'd7 && energia == 3'd7 &&
                 entretenimiento == 3'd7 && higiene == 3'd7) begin
      cand = CodeFeliz;
    end
  end

  // State register and all registered datapath/outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StEstable;
      cand_q       <= CodeNeutral;
      estado_q     <= CodeNeutral;
      pend_q       <= CodeNeutral;
      dwell_q      <= 4'd0;
      tick_cnt_q   <= 4'd0;
      frame_q      <= 2'd0;
      cambio_q     <= 1'b0;
      alerta_q     <= 1'b0;
      passsecond_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand;
      estado_q     <= estado_d;
      pend_q       <= pend_d;
      dwell_q      <= dwell_d;
      tick_cnt_q   <= tick_cnt_d;
      frame_q      <= frame_d;
      cambio_q     <= cambio_d;
      alerta_q     <= alerta_d;
      passsecond_q <= passsecond;
    end
  end

  // Next-state logic: commit urgent candidates at once, debounce the rest over DWELL ticks.
  always_comb begin
    state_d   = state_q;
    estado_d  = estado_q;
    pend_d    = pend_q;
    dwell_d   = dwell_q;
    commit    = 1'b0;
    dwell_inc = dwell_q + 4'd1;
    unique case (state_q)
      StEstable: begin
        if (cand_q != estado_q) begin
          if (cand_urgent) begin
            estado_d = cand_q;
            commit   = 1'b1;
          end else begin
            pend_d  = cand_q;
            dwell_d = 4'd0;
            state_d = StPendiente;
          end
        end
      end
      StPendiente: begin
        // Reversion is checked first so an urgent estado is never re-committed to itself.
        if (cand_q == estado_q) begin
          state_d = StEstable;
        end else if (cand_urgent) begin
          estado_d = cand_q;
          commit   = 1'b1;
          state_d  = StEstable;
        end else if (cand_q != pend_q) begin
          pend_d  = cand_q;
          dwell_d = 4'd0;
        end else if (tk) begin
          dwell_d = dwell_inc;
          if (dwell_inc == DwellLim) begin
            estado_d = pend_q;
            commit   = 1'b1;
            state_d  = StEstable;
          end
        end
      end
      default: state_d = StEstable;
    endcase
  end

  // Output logic: change strobe, alert from the new estado, frame counter (commit wins).
  always_comb begin
    cambio_d   = commit;
    alerta_d   = (estado_d == CodeMoribundo) || (estado_d == CodeCritico);
    frame_d    = frame_q;
    tick_cnt_d = tick_cnt_q;
    tick_inc   = tick_cnt_q + 4'd1;
    if (commit) begin
      frame_d    = 2'd0;
      tick_cnt_d = 4'd0;
    end else if (tk) begin
      if (tick_inc >= FrameLim) begin
        frame_d    = frame_q + 2'd1;
        tick_cnt_d = 4'd0;
      end else begin
        tick_cnt_d = tick_inc;
      end
    end
  end

  assign estado = estado_q;
  assign cambio = cambio_q;
  assign alerta = alerta_q;
  assign frame  = frame_q;

endmodule

// File: tb/tb_selector_estado.sv
// Directed bench for selector_estado with DWELL=3, FRAME_TICKS=1.
module tb_selector_estado;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       passsecond = 1'b0;
  logic [2:0] salud = 3'd6;
  logic [2:0] alimentacion = 3'd6;
  logic [2:0] energia = 3'd6;
  logic [2:0] entretenimiento = 3'd6;
  logic [2:0] higiene = 3'd6;
  logic       dormido = 1'b0;
  logic [3:0] estado;
  logic       cambio;
  logic       alerta;
  logic [1:0] frame;

  int checks = 0;
  int errors = 0;
  int cambio_cnt = 0;
  int c0;
  logic [1:0] exp_frame [5];

  selector_estado #(
    .DWELL      (3),
    .FRAME_TICKS(1)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .passsecond     (passsecond),
    .salud          (salud),
    .alimentacion   (alimentacion),
    .energia        (energia),
    .entretenimiento(entretenimiento),
    .higiene        (higiene),
    .dormido        (dormido),
    .estado         (estado),
    .cambio         (cambio),
    .alerta         (alerta),
    .frame          (frame)
  );

  always #5 clk = ~clk;

  // Count cycles with cambio high, sampled away from the active edge.
  always @(negedge clk) if (cambio === 1'b1) cambio_cnt++;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    passsecond = 1'b1;
    step();
    passsecond = 1'b0;
    step();
  endtask

  initial begin
    exp_frame[0] = 2'd1;
    exp_frame[1] = 2'd2;
    exp_frame[2] = 2'd3;
    exp_frame[3] = 2'd0;
    exp_frame[4] = 2'd1;

    // Reset with all levels 6.
    step();
    check("rst_estado", 8'(estado), 8'h0A);
    check("rst_cambio", 8'(cambio), 8'h00);
    check("rst_alerta", 8'(alerta), 8'h00);
    check("rst_frame", 8'(frame), 8'h00);
    reset_n = 1'b1;
    step(); step(); step();
    check("steady_estado", 8'(estado), 8'h0A);

    // Non-urgent: higiene 6->4, three ticks to commit SUCIO.
    higiene = 3'd4;
    step(); step(); step();
    check("sucio_pend_state", 8'(dut.state_q), 8'h01);
    pulse();
    pulse();
    check("sucio_2ticks_estado", 8'(estado), 8'h0A);
    check("sucio_2ticks_frame", 8'(frame), 8'h02);
    c0 = cambio_cnt;
    passsecond = 1'b1;
    step();
    check("sucio_estado", 8'(estado), 8'h06);
    check("sucio_cambio", 8'(cambio), 8'h01);
    check("sucio_frame", 8'(frame), 8'h00);
    passsecond = 1'b0;
    step();
    check("sucio_cambio_drop", 8'(cambio), 8'h00);
    check("sucio_one_pulse", 8'(cambio_cnt - c0), 8'h01);

    // Urgent: salud -> 2, CRITICO two clocks later with no tick.
    salud = 3'd2;
    step();
    check("crit_lat1_estado", 8'(estado), 8'h06);
    step();
    check("crit_estado", 8'(estado), 8'h07);
    check("crit_alerta", 8'(alerta), 8'h01);
    check("crit_cambio", 8'(cambio), 8'h01);
    step();
    check("crit_cambio_drop", 8'(cambio), 8'h00);

    // Recover to NEUTRAL (non-urgent, needs three ticks).
    salud = 3'd6;
    higiene = 3'd6;
    step(); step(); step();
    c0 = cambio_cnt;
    pulse(); pulse(); pulse();
    check("recover_estado", 8'(estado), 8'h0A);
    check("recover_alerta", 8'(alerta), 8'h00);
    check("recover_one_pulse", 8'(cambio_cnt - c0), 8'h01);

    // Glitch: alimentacion 6->4 for two ticks, then back.
    c0 = cambio_cnt;
    alimentacion = 3'd4;
    step(); step(); step();
    pulse(); pulse();
    alimentacion = 3'd6;
    step(); step();
    check("glitch_state", 8'(dut.state_q), 8'h00);
    check("glitch_estado", 8'(estado), 8'h0A);
    pulse(); pulse(); pulse();
    check("glitch_estado_late", 8'(estado), 8'h0A);
    check("glitch_no_cambio", 8'(cambio_cnt - c0), 8'h00);

    // dormido and salud=1 together: MORIBUNDO wins.
    dormido = 1'b1;
    salud = 3'd1;
    step();
    check("mori_lat1_estado", 8'(estado), 8'h0A);
    step();
    check("mori_estado", 8'(estado), 8'h08);
    check("mori_alerta", 8'(alerta), 8'h01);
    check("mori_cambio", 8'(cambio), 8'h01);

    // Back to NEUTRAL, then frame sequence over five ticks.
    dormido = 1'b0;
    salud = 3'd6;
    step(); step(); step();
    pulse(); pulse(); pulse();
    step();
    check("frame_base_estado", 8'(estado), 8'h0A);
    check("frame_base", 8'(frame), 8'h00);
    for (int i = 0; i < 5; i++) begin
      pulse();
      check($sformatf("frame_%0d", i), 8'(frame), 8'(exp_frame[i]));
    end

    // Reset in the middle of PENDIENTE.
    higiene = 3'd4;
    step(); step(); step();
    pulse();
    check("mid_pend_state", 8'(dut.state_q), 8'h01);
    reset_n = 1'b0;
    higiene = 3'd6;
    #1;
    check("async_rst_estado", 8'(estado), 8'h0A);
    check("async_rst_cambio", 8'(cambio), 8'h00);
    check("async_rst_alerta", 8'(alerta), 8'h00);
    check("async_rst_frame", 8'(frame), 8'h00);
    check("async_rst_state", 8'(dut.state_q), 8'h00);
    step(); step();
    c0 = cambio_cnt;
    reset_n = 1'b1;
    step(); step(); step();
    pulse(); pulse(); pulse();
    check("post_rst_estado", 8'(estado), 8'h0A);
    check("post_rst_no_cambio", 8'(cambio_cnt - c0), 8'h00);
    check("post_rst_frame", 8'(frame), 8'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
